// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
//   Shared constants and types for the convolution datapath blocks.
//   DATA_W   : pixel / weight width (signed)
//   BIAS_W   : bias width (signed)
//   ACC_W    : accumulator width (signed). The worst-case magnitude is
//              9*128*128 + 2^15, which fits in 19 bits; one guard bit added.
//   NUM_TAPS : number of taps in a 3x3 window
//   SAT_MAX / SAT_MIN : int8 saturation limits of the requantized output
//   conv_state_e : kernel load / run state of the MAC front end
// ----------------------------------------------------------------------------
package conv_pkg;

    localparam int DATA_W   = 8;
    localparam int BIAS_W   = 16;
    localparam int ACC_W    = 20;
    localparam int NUM_TAPS = 9;

    localparam int SAT_MAX  = 127;
    localparam int SAT_MIN  = -128;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } conv_state_e;

endpackage

// File: rtl/requant_relu_sat.sv
// ----------------------------------------------------------------------------
// requant_relu_sat
//   Combinational requantization of a signed accumulator to a signed int8
//   pixel: optional ReLU, round-half-up arithmetic right shift, saturation.
//   Shared by the convolution, pointwise and pooling stages.
//
//   acc_in    in   ACC_W (s)   accumulator value
//   relu_en   in   1           1: negative accumulators become 0 first
//   shift_amt in   5           right shift, 0..19 (0 = no rounding, no shift)
//   pix_out   out  DATA_W (s)  saturated result in [SAT_MIN, SAT_MAX]
// ----------------------------------------------------------------------------
module requant_relu_sat
    import conv_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic                     relu_en,
    input  logic        [4:0]        shift_amt,
    output logic signed [DATA_W-1:0] pix_out
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(SAT_MAX);
    localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(SAT_MIN);

    logic signed [EXT_W-1:0] relu_val;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        relu_val = {acc_in[ACC_W-1], acc_in};
        if (relu_en && acc_in[ACC_W-1]) begin
            relu_val = '0;
        end

        // Half an output LSB, so the arithmetic shift rounds half up.
        rnd = '0;
        if (shift_amt != 5'd0) begin
            rnd = EXT_W'(1) << (shift_amt - 5'd1);
        end

        rounded = relu_val + rnd;
        shifted = rounded >>> shift_amt;

        if (shifted > SAT_HI) begin
            pix_out = DATA_W'(SAT_MAX);
        end else if (shifted < SAT_LO) begin
            pix_out = DATA_W'(SAT_MIN);
        end else begin
            pix_out = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_mac_requant.sv
// ----------------------------------------------------------------------------
// conv3x3_mac_requant
//   3x3 int8 convolution of one window per cycle against a streamed-in kernel,
//   followed by bias add and requantization to int8. Four register stages:
//   S1 products, S2 row sums, S3 total + bias, S4 requantized output.
//
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   win0..win8    in    window pixels, row-major (win4 = centre)
//   win_valid     in    window present; taken only while kernel_rdy=1
//   wgt_start     in    restart kernel load (wins over wgt_valid)
//   wgt_valid     in    wgt_data carries the next coefficient k0..k8
//   wgt_data      in    coefficient
//   bias          in    quasi-static bias, used in S3
//   shift_amt     in    quasi-static requant shift, used in S4
//   relu_en       in    quasi-static ReLU enable, used in S4
//   kernel_rdy    out   kernel complete; windows are accepted
//   pix_out       out   output pixel, holds between strobes
//   pix_valid     out   one-cycle strobe per accepted window, 4 cycles later
//   drop_err      out   sticky: a window arrived while kernel_rdy=0
//
//   Handshake: no backpressure. A window is consumed exactly in the cycle
//   where win_valid=1 and kernel_rdy=1; otherwise it is dropped and flagged.
//   pix_valid is a pure strobe with no ready; the consumer must take it.
// ----------------------------------------------------------------------------
module conv3x3_mac_requant
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] win0,
    input  logic signed [DATA_W-1:0] win1,
    input  logic signed [DATA_W-1:0] win2,
    input  logic signed [DATA_W-1:0] win3,
    input  logic signed [DATA_W-1:0] win4,
    input  logic signed [DATA_W-1:0] win5,
    input  logic signed [DATA_W-1:0] win6,
    input  logic signed [DATA_W-1:0] win7,
    input  logic signed [DATA_W-1:0] win8,
    input  logic                     win_valid,
    input  logic                     wgt_start,
    input  logic                     wgt_valid,
    input  logic signed [DATA_W-1:0] wgt_data,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic        [4:0]        shift_amt,
    input  logic                     relu_en,
    output logic                     kernel_rdy,
    output logic signed [DATA_W-1:0] pix_out,
    output logic                     pix_valid,
    output logic                     drop_err
);

    localparam int PROD_W = 2 * DATA_W;

    // Kernel load FSM and kernel storage
    conv_state_e              state_q, state_d;
    logic        [3:0]        wgt_cnt_q, wgt_cnt_d;
    logic signed [DATA_W-1:0] k_q [NUM_TAPS];
    logic signed [DATA_W-1:0] k_d [NUM_TAPS];
    logic                     kernel_rdy_q, kernel_rdy_d;
    logic                     drop_err_q, drop_err_d;

    // Pipeline
    logic signed [DATA_W-1:0] win_arr [NUM_TAPS];
    logic                     win_accept;
    logic signed [PROD_W-1:0] p_q [NUM_TAPS];
    logic signed [PROD_W-1:0] p_d [NUM_TAPS];
    logic signed [ACC_W-1:0]  r_q [3];
    logic signed [ACC_W-1:0]  r_d [3];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     v1_q, v1_d;
    logic                     v2_q, v2_d;
    logic                     v3_q, v3_d;
    logic signed [DATA_W-1:0] rq_pix;
    logic signed [DATA_W-1:0] pix_out_q, pix_out_d;
    logic                     pix_valid_q, pix_valid_d;

    always_comb begin
        win_arr = '{win0, win1, win2, win3, win4, win5, win6, win7, win8};
    end

    assign win_accept = win_valid && kernel_rdy_q;

    // ------------------------------------------------------------------
    // Kernel load FSM. The restart path also captures a coefficient that
    // arrives in the same cycle as k0, so a loader can stream without a gap.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wgt_cnt_d    = wgt_cnt_q;
        k_d          = k_q;
        kernel_rdy_d = kernel_rdy_q;

        if (wgt_start) begin
            state_d      = ST_LOAD;
            kernel_rdy_d = 1'b0;
            wgt_cnt_d    = 4'd0;
            if (wgt_valid) begin
                k_d[0]    = wgt_data;
                wgt_cnt_d = 4'd1;
            end
        end else if (state_q == ST_LOAD && wgt_valid) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (wgt_cnt_q == 4'(i)) begin
                    k_d[i] = wgt_data;
                end
            end
            if (wgt_cnt_q == 4'(NUM_TAPS - 1)) begin
                state_d      = ST_RUN;
                kernel_rdy_d = 1'b1;
                wgt_cnt_d    = 4'd0;
            end else begin
                wgt_cnt_d = wgt_cnt_q + 4'd1;
            end
        end

        drop_err_d = drop_err_q || (win_valid && !kernel_rdy_q);
    end

    // ------------------------------------------------------------------
    // S1..S3 datapath. Products are formed from the kernel registers at S1,
    // so a reload afterwards cannot disturb windows already in flight.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            p_d[i] = win_arr[i] * k_q[i];
        end
        for (int j = 0; j < 3; j++) begin
            r_d[j] = ACC_W'(p_q[3*j]) + ACC_W'(p_q[3*j+1]) + ACC_W'(p_q[3*j+2]);
        end
        acc_d = r_q[0] + r_q[1] + r_q[2] + ACC_W'(bias);

        v1_d        = win_accept;
        v2_d        = v1_q;
        v3_d        = v2_q;
        pix_valid_d = v3_q;
        pix_out_d   = v3_q ? rq_pix : pix_out_q;
    end

    requant_relu_sat u_requant (
        .acc_in    (acc_q),
        .relu_en   (relu_en),
        .shift_amt (shift_amt),
        .pix_out   (rq_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            wgt_cnt_q    <= 4'd0;
            kernel_rdy_q <= 1'b0;
            drop_err_q   <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                k_q[i] <= '0;
                p_q[i] <= '0;
            end
            for (int j = 0; j < 3; j++) begin
                r_q[j] <= '0;
            end
            acc_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wgt_cnt_q    <= wgt_cnt_d;
            kernel_rdy_q <= kernel_rdy_d;
            drop_err_q   <= drop_err_d;
            k_q          <= k_d;
            p_q          <= p_d;
            r_q          <= r_d;
            acc_q        <= acc_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            v3_q         <= v3_d;
            pix_out_q    <= pix_out_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    assign kernel_rdy = kernel_rdy_q;
    assign pix_out    = pix_out_q;
    assign pix_valid  = pix_valid_q;
    assign drop_err   = drop_err_q;

endmodule
